// File: rtl/axi_w2n_pkg.sv
// rtl/axi_w2n_pkg.sv - shared types, response codes and sizing helpers for the 64->32 read converter
package axi_w2n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    // Severity order matches the encoding, so merging is a plain maximum.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic int log2_int(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int width_ratio(input int src, input int tgt);
        return src / tgt;
    endfunction

endpackage

// File: rtl/axi_w2n_r_pack.sv
// rtl/axi_w2n_r_pack.sv - packs RATIO narrow read beats into one wide beat with merged response
module axi_w2n_r_pack
    import axi_w2n_pkg::*;
#(
    parameter int SOURCE_WIDTH = 64,
    parameter int TARGET_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [7:0]              len,
    input  logic [TARGET_WIDTH-1:0] nar_rdata,
    input  logic [1:0]              nar_rresp,
    input  logic                    nar_rvalid,
    output logic                    nar_rready,
    output logic [SOURCE_WIDTH-1:0] wide_rdata,
    output logic [1:0]              wide_rresp,
    output logic                    wide_rlast,
    output logic                    wide_rvalid,
    input  logic                    wide_rready,
    output logic                    done
);

    localparam int RATIO = width_ratio(SOURCE_WIDTH, TARGET_WIDTH);
    localparam int SUB_W = log2_int(RATIO);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(RATIO - 1);

    logic [SUB_W-1:0]        sub_q,    sub_d;
    logic [7:0]              beat_q,   beat_d;
    logic [1:0]              resp_q,   resp_d;
    logic [SOURCE_WIDTH-1:0] pack_q,   pack_d;
    logic [SOURCE_WIDTH-1:0] rdata_q,  rdata_d;
    logic [1:0]              rresp_q,  rresp_d;
    logic                    rlast_q,  rlast_d;
    logic                    rvalid_q, rvalid_d;

    logic       nar_hs;
    logic       wide_hs;
    logic [1:0] resp_merged;

    // A narrow beat is taken whenever the output register is empty or draining this cycle.
    assign nar_rready = en && (!rvalid_q || wide_rready);
    assign nar_hs     = nar_rready && nar_rvalid;
    assign wide_hs    = rvalid_q && wide_rready;
    assign done       = wide_hs && rlast_q;

    assign wide_rdata  = rdata_q;
    assign wide_rresp  = rresp_q;
    assign wide_rlast  = rlast_q;
    assign wide_rvalid = rvalid_q;

    always_comb begin
        sub_d       = sub_q;
        beat_d      = beat_q;
        resp_d      = resp_q;
        pack_d      = pack_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        rvalid_d    = rvalid_q;
        resp_merged = resp_max(resp_q, nar_rresp);

        if (wide_hs) begin
            rvalid_d = 1'b0;
        end

        if (nar_hs) begin
            pack_d[sub_q*TARGET_WIDTH +: TARGET_WIDTH] = nar_rdata;
            if (sub_q == SUB_LAST) begin
                sub_d    = '0;
                resp_d   = RESP_OKAY;
                rdata_d  = pack_d;
                rresp_d  = resp_merged;
                rlast_d  = (beat_q == len);
                rvalid_d = 1'b1;
                beat_d   = beat_q + 8'd1;
            end else begin
                sub_d  = sub_q + SUB_W'(1);
                resp_d = resp_merged;
            end
        end

        if (done) begin
            sub_d  = '0;
            beat_d = '0;
            resp_d = RESP_OKAY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q    <= '0;
            beat_q   <= '0;
            resp_q   <= RESP_OKAY;
            pack_q   <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            sub_q    <= sub_d;
            beat_q   <= beat_d;
            resp_q   <= resp_d;
            pack_q   <= pack_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: rtl/axi_wide_to_narrow_rd.sv
// rtl/axi_wide_to_narrow_rd.sv - AXI4 read width converter, wide master to narrow slave, one burst in flight
// Optional request checking with SLVERR completion: AXI_W2N_REQ_CHECK_EN
module axi_wide_to_narrow_rd
    import axi_w2n_pkg::*;
#(
    parameter int SOURCE_WIDTH = 64,
    parameter int TARGET_WIDTH = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int ID_WIDTH     = 8
) (
    input  logic                    aclk,
    input  logic                    areset,

    input  logic [ADDR_WIDTH-1:0]   u_axi_araddr,
    input  logic [2:0]              u_axi_arsize,
    input  logic [7:0]              u_axi_arlen,
    input  logic [1:0]              u_axi_arburst,
    input  logic [ID_WIDTH-1:0]     u_axi_arid,
    input  logic                    u_axi_arvalid,
    output logic                    u_axi_arready,

    output logic [SOURCE_WIDTH-1:0] u_axi_rdata,
    output logic [ID_WIDTH-1:0]     u_axi_rid,
    output logic [1:0]              u_axi_rresp,
    output logic                    u_axi_rlast,
    output logic                    u_axi_rvalid,
    input  logic                    u_axi_rready,

    output logic [ADDR_WIDTH-1:0]   d_axi_araddr,
    output logic [2:0]              d_axi_arsize,
    output logic [7:0]              d_axi_arlen,
    output logic [1:0]              d_axi_arburst,
    output logic [ID_WIDTH-1:0]     d_axi_arid,
    output logic                    d_axi_arvalid,
    input  logic                    d_axi_arready,

    input  logic [TARGET_WIDTH-1:0] d_axi_rdata,
    input  logic [ID_WIDTH-1:0]     d_axi_rid,
    input  logic [1:0]              d_axi_rresp,
    input  logic                    d_axi_rlast,
    input  logic                    d_axi_rvalid,
    output logic                    d_axi_rready
);

    localparam int RATIO      = width_ratio(SOURCE_WIDTH, TARGET_WIDTH);
    localparam int RATIO_LOG2 = log2_int(RATIO);
    localparam int MAX_LEN    = 256 / RATIO - 1;
    localparam logic [2:0] TGT_SIZE = 3'(log2_int(TARGET_WIDTH / 8));

    state_t                  state_q,   state_d;
    logic                    ready_q,   ready_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [ID_WIDTH-1:0]     id_q,      id_d;
    logic [7:0]              len_q,     len_d;
    logic [7:0]              arlen_q,   arlen_d;
    logic [2:0]              arsize_q,  arsize_d;
    logic [1:0]              arburst_q, arburst_d;

    logic                    ar_hs;
    logic [7:0]              len_clamped;
    logic [15:0]             arlen_wide;

    logic [SOURCE_WIDTH-1:0] pk_rdata;
    logic [1:0]              pk_rresp;
    logic                    pk_rlast;
    logic                    pk_rvalid;
    logic                    pk_done;

    logic                    unused_inputs;

`ifdef AXI_W2N_REQ_CHECK_EN
    localparam int SRC_SIZE_INT = log2_int(SOURCE_WIDTH / 8);
    localparam logic [2:0] SRC_SIZE = 3'(SRC_SIZE_INT);

    logic [7:0] err_cnt_q, err_cnt_d;
    logic       req_bad;
    logic       err_last;

    assign req_bad  = (u_axi_arsize != SRC_SIZE) || (u_axi_arburst != BURST_INCR) ||
                      (u_axi_araddr[SRC_SIZE_INT-1:0] != '0) || (u_axi_arlen > 8'(MAX_LEN));
    assign err_last = (err_cnt_q == len_q);
`endif

    // Sequencing never looks at the narrow rlast or rid; the beat count alone ends a burst.
    assign unused_inputs = ^{d_axi_rlast, d_axi_rid, u_axi_arsize, u_axi_arburst};

    assign ar_hs = u_axi_arready && u_axi_arvalid;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
`ifdef AXI_W2N_REQ_CHECK_EN
                    state_d = req_bad ? ST_ERR : ST_ADDR;
`else
                    state_d = ST_ADDR;
`endif
                end
            end
            ST_ADDR: begin
                if (d_axi_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (pk_done) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef AXI_W2N_REQ_CHECK_EN
            ST_ERR: begin
                if (u_axi_rready && err_last) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        u_axi_arready = (state_q == ST_IDLE) && ready_q;
        d_axi_arvalid = (state_q == ST_ADDR);
        d_axi_araddr  = addr_q;
        d_axi_arsize  = arsize_q;
        d_axi_arlen   = arlen_q;
        d_axi_arburst = arburst_q;
        d_axi_arid    = id_q;
        u_axi_rdata   = pk_rdata;
        u_axi_rresp   = pk_rresp;
        u_axi_rlast   = pk_rlast;
        u_axi_rvalid  = pk_rvalid;
        u_axi_rid     = id_q;
`ifdef AXI_W2N_REQ_CHECK_EN
        if (state_q == ST_ERR) begin
            u_axi_rdata  = '0;
            u_axi_rresp  = RESP_SLVERR;
            u_axi_rlast  = err_last;
            u_axi_rvalid = 1'b1;
        end
`endif
    end

    // Oversized lengths are clamped so the narrow burst stays legal and the handshakes still close.
    always_comb begin
        ready_d     = 1'b1;
        addr_d      = addr_q;
        id_d        = id_q;
        len_d       = len_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        arburst_d   = arburst_q;
        len_clamped = (u_axi_arlen > 8'(MAX_LEN)) ? 8'(MAX_LEN) : u_axi_arlen;
        arlen_wide  = ((16'(len_clamped) + 16'd1) << RATIO_LOG2) - 16'd1;

        if (ar_hs) begin
            addr_d    = u_axi_araddr;
            id_d      = u_axi_arid;
            len_d     = len_clamped;
            arlen_d   = arlen_wide[7:0];
            arsize_d  = TGT_SIZE;
            arburst_d = BURST_INCR;
`ifdef AXI_W2N_REQ_CHECK_EN
            if (req_bad) begin
                len_d = u_axi_arlen;
            end
`endif
        end
    end

`ifdef AXI_W2N_REQ_CHECK_EN
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == ST_ERR) && u_axi_rready) begin
            err_cnt_d = err_last ? 8'd0 : err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ready_q   <= 1'b0;
            addr_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
        end else begin
            ready_q   <= ready_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
        end
    end

    axi_w2n_r_pack #(
        .SOURCE_WIDTH (SOURCE_WIDTH),
        .TARGET_WIDTH (TARGET_WIDTH)
    ) u_pack (
        .clk         (aclk),
        .rst         (areset),
        .en          (state_q == ST_DATA),
        .len         (len_q),
        .nar_rdata   (d_axi_rdata),
        .nar_rresp   (d_axi_rresp),
        .nar_rvalid  (d_axi_rvalid),
        .nar_rready  (d_axi_rready),
        .wide_rdata  (pk_rdata),
        .wide_rresp  (pk_rresp),
        .wide_rlast  (pk_rlast),
        .wide_rvalid (pk_rvalid),
        .wide_rready (u_axi_rready),
        .done        (pk_done)
    );

endmodule

// File: tb/tb_axi_wide_to_narrow_rd.sv
// tb/tb_axi_wide_to_narrow_rd.sv - scoreboard bench for the 64->32 read converter
module tb_axi_wide_to_narrow_rd;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [7:0]  id;
    } exp_t;

    logic        aclk;
    logic        areset;
    logic [12:0] u_axi_araddr;
    logic [2:0]  u_axi_arsize;
    logic [7:0]  u_axi_arlen;
    logic [1:0]  u_axi_arburst;
    logic [7:0]  u_axi_arid;
    logic        u_axi_arvalid;
    logic        u_axi_arready;
    logic [63:0] u_axi_rdata;
    logic [7:0]  u_axi_rid;
    logic [1:0]  u_axi_rresp;
    logic        u_axi_rlast;
    logic        u_axi_rvalid;
    logic        u_axi_rready;
    logic [12:0] d_axi_araddr;
    logic [2:0]  d_axi_arsize;
    logic [7:0]  d_axi_arlen;
    logic [1:0]  d_axi_arburst;
    logic [7:0]  d_axi_arid;
    logic        d_axi_arvalid;
    logic        d_axi_arready;
    logic [31:0] d_axi_rdata;
    logic [7:0]  d_axi_rid;
    logic [1:0]  d_axi_rresp;
    logic        d_axi_rlast;
    logic        d_axi_rvalid;
    logic        d_axi_rready;

    int   checks = 0;
    int   errors = 0;
    int   mon_cnt = 0;
    exp_t exp_q[$];

    logic [31:0] nd [0:255];
    logic [1:0]  nr [0:255];

    int          slv_rem = 0;
    int          slv_k = 0;
    logic [7:0]  slv_id = 8'h00;

    axi_wide_to_narrow_rd dut (
        .aclk          (aclk),
        .areset        (areset),
        .u_axi_araddr  (u_axi_araddr),
        .u_axi_arsize  (u_axi_arsize),
        .u_axi_arlen   (u_axi_arlen),
        .u_axi_arburst (u_axi_arburst),
        .u_axi_arid    (u_axi_arid),
        .u_axi_arvalid (u_axi_arvalid),
        .u_axi_arready (u_axi_arready),
        .u_axi_rdata   (u_axi_rdata),
        .u_axi_rid     (u_axi_rid),
        .u_axi_rresp   (u_axi_rresp),
        .u_axi_rlast   (u_axi_rlast),
        .u_axi_rvalid  (u_axi_rvalid),
        .u_axi_rready  (u_axi_rready),
        .d_axi_araddr  (d_axi_araddr),
        .d_axi_arsize  (d_axi_arsize),
        .d_axi_arlen   (d_axi_arlen),
        .d_axi_arburst (d_axi_arburst),
        .d_axi_arid    (d_axi_arid),
        .d_axi_arvalid (d_axi_arvalid),
        .d_axi_arready (d_axi_arready),
        .d_axi_rdata   (d_axi_rdata),
        .d_axi_rid     (d_axi_rid),
        .d_axi_rresp   (d_axi_rresp),
        .d_axi_rlast   (d_axi_rlast),
        .d_axi_rvalid  (d_axi_rvalid),
        .d_axi_rready  (d_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic push_burst(input int len, input logic [7:0] id);
        exp_t e;
        for (int w = 0; w <= len; w++) begin
            e.data = '0;
            e.resp = 2'b00;
            for (int s = 0; s < 2; s++) begin
                e.data[s*32 +: 32] = nd[w*2+s];
                e.resp = rmax(e.resp, nr[w*2+s]);
            end
            e.last = (w == len);
            e.id   = id;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_ar(input logic [12:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [7:0] id, output int waited);
        logic ok;
        ok = 1'b0;
        waited = 0;
        u_axi_araddr  = addr;
        u_axi_arlen   = len;
        u_axi_arsize  = size;
        u_axi_arburst = 2'b01;
        u_axi_arid    = id;
        u_axi_arvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            if (u_axi_arready) ok = 1'b1;
            else waited++;
        end
        check("ar_accepted", {63'b0, ok}, 64'd1);
        @(posedge aclk);
        #1;
        u_axi_arvalid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge aclk);
            #1;
            if (exp_q.size() == 0) ok = 1'b1;
        end
        check("burst_done", {63'b0, ok}, 64'd1);
    endtask

    // Narrow slave: samples handshakes mid-cycle, updates just after the rising edge.
    initial begin
        logic       s_ar, s_r;
        logic [7:0] s_len, s_id;
        d_axi_arready = 1'b1;
        d_axi_rvalid  = 1'b0;
        d_axi_rdata   = '0;
        d_axi_rresp   = 2'b00;
        d_axi_rlast   = 1'b0;
        d_axi_rid     = '0;
        forever begin
            @(negedge aclk);
            s_ar  = d_axi_arvalid && d_axi_arready;
            s_r   = d_axi_rvalid && d_axi_rready;
            s_len = d_axi_arlen;
            s_id  = d_axi_arid;
            @(posedge aclk);
            #1;
            if (areset) begin
                slv_rem = 0;
                slv_k   = 0;
            end else begin
                if (s_r) begin
                    slv_k++;
                    slv_rem--;
                end
                if (s_ar) begin
                    slv_rem = int'(s_len) + 1;
                    slv_k   = 0;
                    slv_id  = s_id;
                end
            end
            d_axi_rvalid = (slv_rem > 0);
            d_axi_rdata  = nd[slv_k[7:0]];
            d_axi_rresp  = nr[slv_k[7:0]];
            d_axi_rlast  = (slv_rem == 1);
            d_axi_rid    = slv_id;
        end
    end

    // Wide-side monitor: pops the scoreboard on every upstream R handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (!areset && u_axi_rvalid && u_axi_rready) begin
                check("r_expected", {63'b0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rdata", u_axi_rdata, e.data);
                    check("rresp", {62'b0, u_axi_rresp}, {62'b0, e.resp});
                    check("rlast", {63'b0, u_axi_rlast}, {63'b0, e.last});
                    check("rid", {56'b0, u_axi_rid}, {56'b0, e.id});
                end
                mon_cnt++;
            end
        end
    end

    initial begin
        int   waited;
        int   base;
        logic ok;
        int   arv_seen;

        areset        = 1'b1;
        u_axi_arvalid = 1'b0;
        u_axi_araddr  = '0;
        u_axi_arsize  = '0;
        u_axi_arlen   = '0;
        u_axi_arburst = '0;
        u_axi_arid    = '0;
        u_axi_rready  = 1'b1;
        for (int k = 0; k < 256; k++) begin
            nd[k] = '0;
            nr[k] = 2'b00;
        end

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_arready", {63'b0, u_axi_arready}, 64'd0);
        check("rst_rvalid", {63'b0, u_axi_rvalid}, 64'd0);
        check("rst_rlast", {63'b0, u_axi_rlast}, 64'd0);
        check("rst_rdata", u_axi_rdata, 64'd0);
        check("rst_rid", {56'b0, u_axi_rid}, 64'd0);
        check("rst_d_arvalid", {63'b0, d_axi_arvalid}, 64'd0);
        check("rst_d_rready", {63'b0, d_axi_rready}, 64'd0);
        check("rst_d_arlen", {56'b0, d_axi_arlen}, 64'd0);
        check("rst_d_arsize", {61'b0, d_axi_arsize}, 64'd0);
        areset = 1'b0;
        #1;
        check("arready_held_after_release", {63'b0, u_axi_arready}, 64'd0);
        @(posedge aclk);
        #1;
        check("arready_first_edge", {63'b0, u_axi_arready}, 64'd1);

        // Basic 4-beat burst with AR and first-beat timing
        for (int k = 0; k < 8; k++) nd[k] = 32'((k + 1) * 32'h11111111);
        push_burst(3, 8'h5A);
        do_ar(13'h100, 8'd3, 3'd3, 8'h5A, waited);
        check("d_arvalid_t1", {63'b0, d_axi_arvalid}, 64'd1);
        check("d_araddr", {51'b0, d_axi_araddr}, 64'h100);
        check("d_arlen", {56'b0, d_axi_arlen}, 64'd7);
        check("d_arsize", {61'b0, d_axi_arsize}, 64'd2);
        check("d_arburst", {62'b0, d_axi_arburst}, 64'd1);
        check("d_arid", {56'b0, d_axi_arid}, 64'h5A);
        check("arready_busy", {63'b0, u_axi_arready}, 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        check("rvalid_not_yet", {63'b0, u_axi_rvalid}, 64'd0);
        @(posedge aclk);
        #1;
        check("rvalid_after_ratio", {63'b0, u_axi_rvalid}, 64'd1);
        wait_done(100);
        check("arready_after_burst", {63'b0, u_axi_arready}, 64'd1);

        // Upstream stall on wide beat 1
        base = mon_cnt;
        push_burst(3, 8'h21);
        do_ar(13'h100, 8'd3, 3'd3, 8'h21, waited);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge aclk);
            #1;
            if (mon_cnt == base + 1) ok = 1'b1;
        end
        check("stall_reach_beat1", {63'b0, ok}, 64'd1);
        u_axi_rready = 1'b0;
        repeat (2) @(negedge aclk);
        check("stall_rvalid_a", {63'b0, u_axi_rvalid}, 64'd1);
        check("stall_d_rready_a", {63'b0, d_axi_rready}, 64'd0);
        check("stall_rdata_a", u_axi_rdata, exp_q[0].data);
        repeat (3) @(negedge aclk);
        check("stall_rvalid_b", {63'b0, u_axi_rvalid}, 64'd1);
        check("stall_d_rready_b", {63'b0, d_axi_rready}, 64'd0);
        check("stall_rdata_b", u_axi_rdata, exp_q[0].data);
        @(posedge aclk);
        #1;
        u_axi_rready = 1'b1;
        wait_done(100);

        // SLVERR on narrow beat 5 lands in wide beat 2
        nr[5] = 2'b10;
        push_burst(3, 8'h33);
        do_ar(13'h100, 8'd3, 3'd3, 8'h33, waited);
        wait_done(100);
        nr[5] = 2'b00;

        // Mixed response merge: EXOKAY over OKAY, DECERR over SLVERR
        nr[0] = 2'b01;
        nr[2] = 2'b10;
        nr[3] = 2'b11;
        push_burst(1, 8'h3C);
        do_ar(13'h040, 8'd1, 3'd3, 8'h3C, waited);
        check("d_arlen_len1", {56'b0, d_axi_arlen}, 64'd3);
        wait_done(100);
        for (int k = 0; k < 4; k++) nr[k] = 2'b00;

        // Back-to-back: shortest then longest burst
        for (int k = 0; k < 256; k++) nd[k] = {8'hB0, 8'h00, 16'(k)};
        push_burst(0, 8'h12);
        do_ar(13'h200, 8'd0, 3'd3, 8'h12, waited);
        check("b2b_arlen0", {56'b0, d_axi_arlen}, 64'd1);
        check("b2b_arid0", {56'b0, d_axi_arid}, 64'h12);
        wait_done(100);
        check("b2b_gap_arready", {63'b0, u_axi_arready}, 64'd1);
        push_burst(127, 8'h34);
        do_ar(13'h400, 8'd127, 3'd3, 8'h34, waited);
        check("b2b_ar_no_wait", waited, 64'd0);
        check("b2b_arlen_max", {56'b0, d_axi_arlen}, 64'd255);
        check("b2b_arid1", {56'b0, d_axi_arid}, 64'h34);
        wait_done(700);

        // Reset in the middle of a burst
        for (int k = 0; k < 8; k++) nd[k] = 32'((k + 1) * 32'h11111111);
        push_burst(3, 8'h44);
        do_ar(13'h100, 8'd3, 3'd3, 8'h44, waited);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            if (slv_k == 3) ok = 1'b1;
        end
        check("mid_reach_3_beats", {63'b0, ok}, 64'd1);
        areset = 1'b1;
        #1;
        check("mid_rst_arready", {63'b0, u_axi_arready}, 64'd0);
        check("mid_rst_rvalid", {63'b0, u_axi_rvalid}, 64'd0);
        check("mid_rst_rdata", u_axi_rdata, 64'd0);
        check("mid_rst_rid", {56'b0, u_axi_rid}, 64'd0);
        check("mid_rst_d_arvalid", {63'b0, d_axi_arvalid}, 64'd0);
        check("mid_rst_d_rready", {63'b0, d_axi_rready}, 64'd0);
        check("mid_rst_d_arlen", {56'b0, d_axi_arlen}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        for (int k = 0; k < 8; k++) nd[k] = 32'hC000_0000 | 32'(k);
        push_burst(1, 8'h55);
        do_ar(13'h080, 8'd1, 3'd3, 8'h55, waited);
        check("post_rst_arlen", {56'b0, d_axi_arlen}, 64'd3);
        check("post_rst_araddr", {51'b0, d_axi_araddr}, 64'h080);
        wait_done(100);

`ifdef AXI_W2N_REQ_CHECK_EN
        // Unsupported size: SLVERR completion without a downstream request
        begin
            exp_t e;
            for (int w = 0; w < 2; w++) begin
                e.data = '0;
                e.resp = 2'b10;
                e.last = (w == 1);
                e.id   = 8'h66;
                exp_q.push_back(e);
            end
        end
        do_ar(13'h100, 8'd1, 3'd2, 8'h66, waited);
        arv_seen = 0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (d_axi_arvalid) arv_seen++;
            @(posedge aclk);
            #1;
            if (exp_q.size() == 0) ok = 1'b1;
        end
        check("err_burst_done", {63'b0, ok}, 64'd1);
        check("err_no_d_arvalid", arv_seen, 64'd0);
`else
        arv_seen = 0;
`endif

        repeat (3) @(posedge aclk);
        check("scoreboard_empty", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
